// File: rtl/rd_fram_buf_hdmi_if.sv
// rd_fram_buf_hdmi_if: DDR read channel, pixel port and status of the HDMI read-side frame buffer
interface rd_fram_buf_hdmi_if #(
  parameter int IN_DATA_WIDTH  = 128,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int DEPTH_WORDS    = 512
);
  logic                              frame_start;
  logic                              rd_req;
  logic                              rd_req_ack;
  logic [IN_DATA_WIDTH-1:0]          ddr_rdata;
  logic                              ddr_rdata_vld;
  logic                              pix_req;
  logic [OUT_DATA_WIDTH-1:0]         pix_data;
  logic                              pix_vld;
  logic [$clog2(DEPTH_WORDS*4):0]    level;
  logic                              underflow;
  logic                              burst_err;
  logic                              frame_done;
  modport master (
    output frame_start, rd_req_ack, ddr_rdata, ddr_rdata_vld, pix_req,
    input  rd_req, pix_data, pix_vld, level, underflow, burst_err, frame_done
  );
  modport slave (
    input  frame_start, rd_req_ack, ddr_rdata, ddr_rdata_vld, pix_req,
    output rd_req, pix_data, pix_vld, level, underflow, burst_err, frame_done
  );
endinterface

// File: rtl/rd_fram_buf_hdmi.sv
// rd_fram_buf_hdmi: fetches frame bursts from DDR into a word RAM and hands out one 32-bit pixel per request
module rd_fram_buf_hdmi #(
  parameter int IN_DATA_WIDTH  = 128,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int DEPTH_WORDS    = 512,
  parameter int BURST_LEN      = 16,
  parameter int FRAME_WORDS    = 518400
) (
  input  logic              clk,
  input  logic              rst,
  rd_fram_buf_hdmi_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = AW + 3;
  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam int BW = $clog2(BURST_LEN);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;
  state_t                    state_q, state_d;
  logic [AW:0]               wr_ptr_q, wr_ptr_d;
  logic [AW+2:0]             rd_pix_ptr_q, rd_pix_ptr_d;
  logic [CW-1:0]             req_cnt_q, req_cnt_d;
  logic [BW-1:0]             beat_cnt_q, beat_cnt_d;
  logic                      underflow_q, underflow_d;
  logic                      burst_err_q, burst_err_d;
  logic                      pix_vld_q, pix_vld_d;
  logic [OUT_DATA_WIDTH-1:0] pix_data_q;
  logic [IN_DATA_WIDTH-1:0]  mem [DEPTH_WORDS];
  logic [AW:0]               word_occ;
  logic [AW+1:0]             free_words;
  logic [LW-1:0]             level;
  logic                      req_ok, beat, last_beat, rd_ok, acked;
  // Pointers carry a wrap bit so full and empty stay distinguishable
  assign word_occ   = wr_ptr_q - rd_pix_ptr_q[AW+2:2];
  assign free_words = (AW+2)'(DEPTH_WORDS) - {1'b0, word_occ};
  assign level      = {wr_ptr_q, 2'b00} - rd_pix_ptr_q;
  assign req_ok     = free_words >= (AW+2)'(BURST_LEN) && req_cnt_q < CW'(FRAME_WORDS);
  assign acked      = state_q == REQ && req_ok && bus.rd_req_ack;
  assign beat       = bus.ddr_rdata_vld && state_q == WAIT_DATA && !bus.frame_start;
  assign last_beat  = beat && beat_cnt_q == BW'(BURST_LEN - 1);
  assign rd_ok      = bus.pix_req && level != '0 && !bus.frame_start;
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = beat ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_pix_ptr_d = rd_ok ? rd_pix_ptr_q + 1'b1 : rd_pix_ptr_q;
    req_cnt_d    = acked ? req_cnt_q + CW'(BURST_LEN) : req_cnt_q;
    beat_cnt_d   = last_beat ? '0 : beat ? beat_cnt_q + 1'b1 : beat_cnt_q;
    underflow_d  = underflow_q | (bus.pix_req && level == '0);
    burst_err_d  = burst_err_q | (bus.ddr_rdata_vld && state_q != WAIT_DATA);
    pix_vld_d    = rd_ok;
    case (state_q)
      REQ:       state_d = req_cnt_q == CW'(FRAME_WORDS) ? DONE : acked ? WAIT_DATA : REQ;
      WAIT_DATA: state_d = last_beat ? REQ : WAIT_DATA;
      default:   state_d = state_q;
    endcase
    // A new frame abandons everything in flight, including a half-received burst
    if (bus.frame_start) begin
      state_d      = REQ;
      wr_ptr_d     = '0;
      rd_pix_ptr_d = '0;
      req_cnt_d    = '0;
      beat_cnt_d   = '0;
      underflow_d  = 1'b0;
      burst_err_d  = 1'b0;
      pix_vld_d    = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_pix_ptr_q <= '0;
      req_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      underflow_q  <= 1'b0;
      burst_err_q  <= 1'b0;
      pix_vld_q    <= 1'b0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_pix_ptr_q <= rd_pix_ptr_d;
      req_cnt_q    <= req_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      underflow_q  <= underflow_d;
      burst_err_q  <= burst_err_d;
      pix_vld_q    <= pix_vld_d;
      if (rd_ok) pix_data_q <= mem[rd_pix_ptr_q[AW+1:2]][rd_pix_ptr_q[1:0]*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
    end
  end
  always_ff @(posedge clk) begin
    if (beat) mem[wr_ptr_q[AW-1:0]] <= bus.ddr_rdata;
  end
  assign bus.rd_req     = state_q == REQ && req_ok;
  assign bus.pix_data   = pix_data_q;
  assign bus.pix_vld    = pix_vld_q;
  assign bus.level      = level;
  assign bus.underflow  = underflow_q;
  assign bus.burst_err  = burst_err_q;
  assign bus.frame_done = state_q == DONE;
endmodule

// File: tb/tb_rd_fram_buf_hdmi.sv
// tb_rd_fram_buf_hdmi: directed bench; pixel j of the frame carries value j so expectations are plain counters
module tb_rd_fram_buf_hdmi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs = 1'b0, ack = 1'b0, vld = 1'b0, preq = 1'b0;
  logic [127:0] rdata = '0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  rd_fram_buf_hdmi_if a ();
  rd_fram_buf_hdmi_if b ();
  assign a.frame_start = fs;
  assign a.rd_req_ack = ack;
  assign a.ddr_rdata = rdata;
  assign a.ddr_rdata_vld = vld;
  assign a.pix_req = preq;
  assign b.frame_start = fs;
  assign b.rd_req_ack = ack;
  assign b.ddr_rdata = rdata;
  assign b.ddr_rdata_vld = vld;
  assign b.pix_req = preq;
  rd_fram_buf_hdmi dut (.clk(clk), .rst(rst), .bus(a));
  rd_fram_buf_hdmi #(.FRAME_WORDS(64)) dut_b (.clk(clk), .rst(rst), .bus(b));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] word(input int k);
    return {32'(4*k+3), 32'(4*k+2), 32'(4*k+1), 32'(4*k)};
  endfunction
  task automatic start;
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask
  task automatic burst(input int base, input int n);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("rd_req_drop", a.rd_req, 0);
    for (int i = 0; i < n; i++) begin
      rdata = word(base + i);
      vld = 1'b1;
      tick();
    end
    vld = 1'b0;
  endtask
  task automatic pull(input int first, input int n);
    preq = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("pix_vld", a.pix_vld, 1);
      chk("pix_data", a.pix_data, first + i);
    end
    preq = 1'b0;
  endtask
  initial begin
    int nb;
    repeat (3) tick();
    chk("rst_rd_req", a.rd_req, 0);
    chk("rst_level", a.level, 0);
    chk("rst_pix_vld", a.pix_vld, 0);
    chk("rst_underflow", a.underflow, 0);
    chk("rst_burst_err", a.burst_err, 0);
    chk("rst_frame_done", a.frame_done, 0);
    rst = 1'b0;
    tick();
    chk("idle_rd_req", a.rd_req, 0);
    start();
    chk("first_rd_req", a.rd_req, 1);
    burst(0, 16);
    chk("level_16beats", a.level, 64);
    chk("next_rd_req", a.rd_req, 1);
    burst(16, 16);
    chk("level_32beats", a.level, 128);
    chk("idle_pix_vld", a.pix_vld, 0);
    pull(0, 128);
    tick();
    chk("pix_vld_after", a.pix_vld, 0);
    chk("level_drained", a.level, 0);
    preq = 1'b1;
    tick();
    preq = 1'b0;
    chk("uf_pix_vld", a.pix_vld, 0);
    chk("uf_flag", a.underflow, 1);
    chk("uf_hold_data", a.pix_data, 127);
    tick();
    chk("uf_sticky", a.underflow, 1);
    start();
    chk("uf_cleared", a.underflow, 0);
    nb = 0;
    for (int k = 0; k < 40 && a.rd_req; k++) begin
      burst(nb * 16, 16);
      nb++;
    end
    chk("fill_bursts", nb, 32);
    chk("fill_level", a.level, 2048);
    chk("fill_rd_req", a.rd_req, 0);
    pull(0, 4);
    tick();
    chk("one_word_free_req", a.rd_req, 0);
    chk("level_2044", a.level, 2044);
    pull(4, 60);
    tick();
    chk("burst_free_req", a.rd_req, 1);
    burst(512, 16);
    chk("wrap_level", a.level, 2048);
    pull(64, 2048);
    tick();
    chk("wrap_drained", a.level, 0);
    start();
    chk("flush_rd_req", a.rd_req, 1);
    burst(0, 5);
    start();
    chk("flush_level", a.level, 0);
    for (int i = 0; i < 11; i++) begin
      rdata = word(99);
      vld = 1'b1;
      tick();
    end
    vld = 1'b0;
    chk("stale_level", a.level, 0);
    chk("stale_burst_err", a.burst_err, 1);
    chk("stale_rd_req", a.rd_req, 1);
    burst(0, 16);
    chk("refetch_level", a.level, 64);
    chk("burst_err_sticky", a.burst_err, 1);
    pull(0, 4);
    start();
    for (int k = 0; k < 4; k++) begin
      chk("b_rd_req", b.rd_req, 1);
      burst(k * 16, 16);
      pull(k * 64, 64);
      tick();
    end
    chk("b_frame_done", b.frame_done, 1);
    chk("b_no_req", b.rd_req, 0);
    chk("a_not_done", a.frame_done, 0);
    repeat (5) tick();
    chk("b_still_no_req", b.rd_req, 0);
    start();
    burst(0, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_level", a.level, 0);
    chk("arst_rd_req", a.rd_req, 0);
    rst = 1'b0;
    tick();
    chk("arst_idle", a.rd_req, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
